// File: rtl/pixel_arbiter.sv
// Per-slot sprite arbiter: collects blob fetch requests, picks the highest layer,
// reads sprite RAM once per 25 MHz slot and emits the composed pixel with aligned syncs.
module pixel_arbiter #(
  parameter int N_SPRITES = 4,
  parameter int ADDR_W = 16,
  parameter int RGB_W = 12,
  parameter int RAM_LAT = 1,
  parameter logic [RGB_W-1:0] TRANSP_KEY = '0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clk25en,
  input  logic [N_SPRITES-1:0]          request,
  input  logic [N_SPRITES*ADDR_W-1:0]   address_in,
  input  logic [N_SPRITES*2-1:0]        layer_in,
  input  logic                          blank,
  input  logic                          h_sync,
  input  logic                          v_sync,
  input  logic [RGB_W-1:0]              bg_color,
  output logic                          mem_en,
  output logic [ADDR_W-1:0]             mem_addr,
  input  logic [RGB_W-1:0]              mem_data,
  output logic [RGB_W-1:0]              rgb,
  output logic                          blank_out,
  output logic                          h_sync_out,
  output logic                          v_sync_out,
  output logic [15:0]                   coll_cnt,
  input  logic                          coll_clr
);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [RGB_W-1:0] pick_pixel(input logic blk, input logic vld,
                                                  input logic [RGB_W-1:0] pix,
                                                  input logic [RGB_W-1:0] bg);
    if (blk)
      return '0;
    else if (!vld || pix == TRANSP_KEY)
      return bg;
    else
      return pix;
  endfunction

  logic [N_SPRITES-1:0] pend;
  logic [ADDR_W-1:0]    addr_lat [N_SPRITES];
  logic [1:0]           layer_lat [N_SPRITES];

  logic [N_SPRITES-1:0] eff_pend;
  logic [ADDR_W-1:0]    eff_addr [N_SPRITES];
  logic [1:0]           eff_layer [N_SPRITES];
  logic                 win_found;
  logic [ADDR_W-1:0]    win_addr;
  logic [1:0]           win_layer;
  logic [3:0]           n_req;

  logic                 blank_p1, h_sync_p1, v_sync_p1;
  logic [RAM_LAT-1:0]   en_pipe;
  logic [RGB_W-1:0]     pix_p2;
  logic                 pix_vld_p2;

  // A request in the clk25en cycle is folded into the slot that is ending.
  always_comb begin
    eff_pend  = pend | request;
    win_found = 1'b0;
    win_addr  = '0;
    win_layer = '0;
    n_req     = '0;
    for (int i = 0; i < N_SPRITES; i++) begin
      eff_addr[i]  = request[i] ? address_in[i*ADDR_W +: ADDR_W] : addr_lat[i];
      eff_layer[i] = request[i] ? layer_in[i*2 +: 2] : layer_lat[i];
      if (eff_pend[i]) begin
        n_req = n_req + 4'd1;
        if (!win_found || eff_layer[i] > win_layer) begin
          win_found = 1'b1;
          win_addr  = eff_addr[i];
          win_layer = eff_layer[i];
        end
      end
    end
  end

  // Collect stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend <= '0;
      for (int i = 0; i < N_SPRITES; i++) begin
        addr_lat[i]  <= '0;
        layer_lat[i] <= '0;
      end
    end else begin
      pend <= clk25en ? request : (pend | request);
      for (int i = 0; i < N_SPRITES; i++) begin
        if (request[i]) begin
          addr_lat[i]  <= address_in[i*ADDR_W +: ADDR_W];
          layer_lat[i] <= layer_in[i*2 +: 2];
        end
      end
    end
  end

  // Stage 1: arbitration result, fetch strobe and collision count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blank_p1  <= 1'b1;
      h_sync_p1 <= 1'b1;
      v_sync_p1 <= 1'b1;
      mem_en    <= 1'b0;
      mem_addr  <= '0;
      coll_cnt  <= '0;
    end else begin
      mem_en <= clk25en & win_found;
      if (clk25en) begin
        blank_p1  <= blank;
        h_sync_p1 <= h_sync;
        v_sync_p1 <= v_sync;
        if (win_found)
          mem_addr <= win_addr;
      end
      if (coll_clr)
        coll_cnt <= '0;
      else if (clk25en && n_req >= 4'd2)
        coll_cnt <= sat_inc16(coll_cnt);
    end
  end

  // Stage 2: sprite RAM data capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_pipe    <= '0;
      pix_p2     <= '0;
      pix_vld_p2 <= 1'b0;
    end else begin
      en_pipe <= RAM_LAT'({en_pipe, mem_en});
      if (en_pipe[RAM_LAT-1]) begin
        pix_p2     <= mem_data;
        pix_vld_p2 <= 1'b1;
      end else if (clk25en) begin
        pix_vld_p2 <= 1'b0;
      end
    end
  end

  // Output stage: updates only on slot edges
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb        <= '0;
      blank_out  <= 1'b1;
      h_sync_out <= 1'b1;
      v_sync_out <= 1'b1;
    end else if (clk25en) begin
      rgb        <= pick_pixel(blank_p1, pix_vld_p2, pix_p2, bg_color);
      blank_out  <= blank_p1;
      h_sync_out <= h_sync_p1;
      v_sync_out <= v_sync_p1;
    end
  end

endmodule

// File: doc/pixel_arbiter.md
Name: pixel_arbiter

Overview:
- Sits directly downstream of the blob sprite engines.
- Collects per-pixel fetch requests (address, layer) from up to N_SPRITES blobs during each 25 MHz pixel slot and picks the highest-layer winner.
- Issues one sprite-RAM read per slot and outputs the final RGB pixel, with blank/hsync/vsync delayed to stay aligned with the colour.

Parameters:
- N_SPRITES, 4, number of blob requesters (1..8)
- ADDR_W, 16, sprite RAM address width
- RGB_W, 12, pixel width (RGB444)
- RAM_LAT, 1, sprite RAM read latency in clk cycles (legal 1..2)
- TRANSP_KEY, 12'h000, RAM colour treated as transparent

Ports:
- clk  in  1  system clock (100 MHz)
- reset  in  1  asynchronous, active-high reset
- clk25en  in  1  pixel-slot enable, one-cycle pulse every 4 clk
- request  in  N_SPRITES  per-blob request pulses; bit i from blob i
- address_in  in  N_SPRITES*ADDR_W  packed blob addresses; slice i belongs to blob i
- layer_in  in  N_SPRITES*2  packed blob layers; 3 is top
- blank  in  1  video blank for the current slot
- h_sync  in  1  horizontal sync for the current slot
- v_sync  in  1  vertical sync for the current slot
- bg_color  in  RGB_W  background colour
- mem_en  out  1  sprite RAM read strobe
- mem_addr  out  ADDR_W  sprite RAM read address
- mem_data  in  RGB_W  sprite RAM data, valid RAM_LAT cycles after mem_en
- rgb  out  RGB_W  final pixel
- blank_out  out  1  delayed blank
- h_sync_out  out  1  delayed h_sync
- v_sync_out  out  1  delayed v_sync
- coll_cnt  out  16  saturating count of slots with more than one requester
- coll_clr  in  1  synchronous clear of coll_cnt

Behaviour:

Reset values:
- rgb=0, blank_out=1, h_sync_out=1, v_sync_out=1, mem_en=0, mem_addr=0, coll_cnt=0.
- All internal latches and pending flags cleared.
- Reset asserted mid-slot discards any collected requests and any in-flight fetch.

Collect stage:
- Per blob: pending bit, address latch, layer latch.
- On request[i]=1 in any cycle: set pending[i] and latch that blob's address and layer.
- A repeated request from the same blob within one slot overwrites the earlier one (last wins).
- A request arriving in the same cycle as clk25en belongs to the slot now ending.

Arbitrate (on clk25en):
- Winner = pending blob with the highest layer; ties go to the lowest index.
- Register win_valid, win_addr, and blank/h_sync/v_sync into stage-1 registers.
- Clear all pending bits, except those re-set by a request in that same cycle, which carry into the next slot.
- If the popcount of pending is 2 or more, increment coll_cnt, saturating at 16'hFFFF.
- coll_clr has priority over increment.

Fetch:
- In the cycle after clk25en: if win_valid, pulse mem_en high for exactly one cycle with mem_addr=win_addr.
- mem_addr holds its value until the next fetch.
- Capture mem_data RAM_LAT cycles after mem_en into a pix register.
- No winner: no mem_en pulse; pix marked invalid.

Output (next clk25en):
- rgb = 0 if stage-1 blank=1.
- Otherwise rgb = bg_color if no winner, or if pix == TRANSP_KEY.
- Otherwise rgb = pix.
- blank_out, h_sync_out, v_sync_out take their stage-1 values on the same edge.
- Total latency: sync/blank inputs sampled at clk25en edge k appear on the outputs at edge k+1. Pixel data requested during slot k is shown from edge k+1 through edge k+2.
- Outputs change only on clk25en edges; they hold otherwise.

Arithmetic and widths:
- Layer comparison is 2-bit unsigned.
- coll_cnt never wraps.

Test Plan:
- Blob0 requests addr 0x0010 layer 1, blob2 requests addr 0x0020 layer 3 in the same slot, RAM returns 12'hF00 -> one mem_en pulse with mem_addr=0x0020; rgb=12'hF00 at the following clk25en; coll_cnt=1.
- Blob1 and blob3 both request at layer 2, with addrs 0x0005 and 0x0007 -> mem_addr=0x0005 (lowest index wins).
- No requests, bg_color=12'h00F, blank=0 -> no mem_en; rgb=12'h00F. Same with blank=1 -> rgb=0, blank_out=1 one slot later.
- Single request whose RAM data equals 12'h000 -> rgb=bg_color.
- Request arriving on the clk25en cycle, then reset asserted 2 cycles into the next slot -> outputs return to reset values immediately; no mem_en after reset is released until a new request.
- Drive more than 65535 collision slots (force the counter near its limit) -> coll_cnt holds at 16'hFFFF; coll_clr together with a collision -> coll_cnt=0.
